// File: rtl/mdu_ctrl_pkg.sv
// Shared op encodings, default latencies and the HI/LO result computation for mdu_ctrl.
package mdu_ctrl_pkg;

    localparam int unsigned MD_OP_W     = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned MUL_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF = 10;

    localparam logic [MD_OP_W-1:0] OP_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] OP_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] OP_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] OP_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] OP_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] OP_MFHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] OP_MFLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] OP_MTHI  = 4'd7;
    localparam logic [MD_OP_W-1:0] OP_MTLO  = 4'd8;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    // Full product/quotient for a start op; divisor forced to 1 when zero so no X leaks.
    function automatic hilo_t md_compute(input logic [MD_OP_W-1:0] op,
                                         input logic [DATA_W-1:0]  a,
                                         input logic [DATA_W-1:0]  b);
        hilo_t              r;
        logic [63:0]        prod;
        logic [DATA_W-1:0]  ub;
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic signed [DATA_W-1:0] sq;
        logic signed [DATA_W-1:0] sr;
        r    = '0;
        prod = '0;
        ub   = (b == '0) ? 32'd1 : b;
        sa   = $signed(a);
        sb   = $signed(ub);
        sq   = '0;
        sr   = '0;
        case (op)
            OP_MULT: begin
                prod = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
                r    = hilo_t'(prod);
            end
            OP_MULTU: begin
                prod = {32'h0, a} * {32'h0, b};
                r    = hilo_t'(prod);
            end
            OP_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = '0;
                    r.lo = 32'h8000_0000;
                end else begin
                    sq   = sa / sb;
                    sr   = sa % sb;
                    r.hi = sr;
                    r.lo = sq;
                end
            end
            OP_DIVU: begin
                r.lo = a / ub;
                r.hi = a % ub;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline-side bundle between the E/D stages and the multiply/divide unit.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic [MD_OP_W-1:0] md_op;
    logic [DATA_W-1:0]  src_a;
    logic [DATA_W-1:0]  src_b;
    logic               d_is_md;
    logic               busy;
    logic               stall;
    logic [DATA_W-1:0]  md_out;
    logic               proto_err;

    modport master (output md_op, src_a, src_b, d_is_md,
                    input  busy, stall, md_out, proto_err);
    modport slave  (input  md_op, src_a, src_b, d_is_md,
                    output busy, stall, md_out, proto_err);
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency busy window, pending HI/LO commit, stall and error pulse.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave md
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    hilo_t            r_hilo;
    hilo_t            w_hilo_nxt;
    hilo_t            r_pend;
    hilo_t            w_pend_nxt;
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
    logic             r_proto_err;
    logic             w_proto_err_nxt;

    logic             w_busy;
    logic             w_is_md;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_start;

    assign w_busy   = (r_cnt != '0);
    assign w_is_md  = (md.md_op >= OP_MULT) && (md.md_op <= OP_MTLO);
    assign w_is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
    assign w_is_div = (md.md_op == OP_DIV)  || (md.md_op == OP_DIVU);
    assign w_start  = !w_busy && (w_is_mul || w_is_div);

    // Next-state: start loads counter and pending result, the last busy cycle commits it.
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_hilo_nxt      = r_hilo;
        w_pend_nxt      = r_pend;
        w_pend_vld_nxt  = r_pend_vld;
        w_proto_err_nxt = w_busy && w_is_md;
        if (w_start) begin
            w_cnt_nxt      = w_is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            w_pend_nxt     = md_compute(md.md_op, md.src_a, md.src_b);
            w_pend_vld_nxt = !(w_is_div && (md.src_b == '0));
        end else if (w_busy) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1) && r_pend_vld) begin
                w_hilo_nxt = r_pend;
            end
        end else if (md.md_op == OP_MTHI) begin
            w_hilo_nxt.hi = md.src_a;
        end else if (md.md_op == OP_MTLO) begin
            w_hilo_nxt.lo = md.src_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hilo      <= '0;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_hilo      <= w_hilo_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    always_comb begin
        md.md_out = '0;
        if (md.md_op == OP_MFHI) begin
            md.md_out = r_hilo.hi;
        end else if (md.md_op == OP_MFLO) begin
            md.md_out = r_hilo.lo;
        end
    end

    assign md.busy      = w_busy;
    assign md.stall     = md.d_is_md && (w_busy || w_start);
    assign md.proto_err = r_proto_err;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors plus randomized ops against an arithmetic model.
module tb_mdu_ctrl;

    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl_if mif ();

    mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic dmd);
        mif.md_op   = op;
        mif.src_a   = a;
        mif.src_b   = b;
        mif.d_is_md = dmd;
    endtask

    function automatic int unsigned lat_of(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return MUL_LAT;
        if (op == 4'd3 || op == 4'd4) return DIV_LAT;
        return 0;
    endfunction

    // Architectural effect of an op accepted while idle.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        int          q;
        sa = a;
        sb = b;
        case (op)
            4'd1: begin sp = longint'(sa) * longint'(sb); {m_hi, m_lo} = sp; end
            4'd2: begin up = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = up; end
            4'd3: if (b != 32'h0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else begin
                    q    = sa / sb;
                    m_lo = q;
                    m_hi = 32'(sa - q * sb);
                end
            end
            4'd4: if (b != 32'h0) begin m_lo = a / b; m_hi = a % b; end
            4'd7: m_hi = a;
            4'd8: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic test_reset();
        drive(4'd0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", mif.busy); end
        checks++;
        if (mif.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%0b exp=0", mif.proto_err); end
        checks++;
        if (mif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", mif.stall); end
        checks++;
        if (mif.md_out !== 32'h0) begin errors++; $display("FAIL reset_md_out got=%h exp=0", mif.md_out); end
        mif.md_op = 4'd5;
        #1;
        checks++;
        if (mif.md_out !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", mif.md_out); end
        mif.md_op = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
    endtask

    task automatic test_mult_div();
        vec_t v[5];
        v[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        v[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
        v[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[3] = '{4'd4, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
        foreach (v[k]) begin
            drive(v[k].op, v[k].a, v[k].b, 1'b0);
            @(negedge clk);
            drive(4'd0, 32'h0, 32'h0, 1'b0);
            model_apply(v[k].op, v[k].a, v[k].b);
            for (int i = 0; i < int'(lat_of(v[k].op)); i++) begin
                #1;
                checks++;
                if (mif.busy !== 1'b1) begin errors++; $display("FAIL muldiv_busy vec=%0d cyc=%0d got=%0b exp=1", k, i, mif.busy); end
                @(negedge clk);
            end
            #1;
            checks++;
            if (mif.busy !== 1'b0) begin errors++; $display("FAIL muldiv_idle vec=%0d got=%0b exp=0", k, mif.busy); end
            mif.md_op = 4'd5;
            #1;
            checks++;
            if (mif.md_out !== v[k].hi) begin errors++; $display("FAIL muldiv_hi vec=%0d got=%h exp=%h", k, mif.md_out, v[k].hi); end
            mif.md_op = 4'd6;
            #1;
            checks++;
            if (mif.md_out !== v[k].lo) begin errors++; $display("FAIL muldiv_lo vec=%0d got=%h exp=%h", k, mif.md_out, v[k].lo); end
            mif.md_op = 4'd0;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        drive(4'd1, 32'd6, 32'd7, 1'b1);
        #1;
        checks++;
        if (mif.stall !== 1'b1) begin errors++; $display("FAIL stall_start got=%0b exp=1", mif.stall); end
        @(negedge clk);
        model_apply(4'd1, 32'd6, 32'd7);
        drive(4'd0, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            #1;
            checks++;
            if (mif.stall !== 1'b1) begin errors++; $display("FAIL stall_busy cyc=%0d got=%0b exp=1", i, mif.stall); end
            @(negedge clk);
        end
        #1;
        checks++;
        if (mif.stall !== 1'b0) begin errors++; $display("FAIL stall_release got=%0b exp=0", mif.stall); end
        mif.d_is_md = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_proto_err();
        drive(4'd3, 32'd100, 32'd7, 1'b0);
        @(negedge clk);
        model_apply(4'd3, 32'd100, 32'd7);
        for (int i = 0; i < int'(DIV_LAT); i++) begin
            if (i == 1) drive(4'd7, 32'h1234_5678, 32'h0, 1'b1);
            else        drive(4'd0, 32'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (mif.proto_err !== (i == 2)) begin errors++; $display("FAIL proto_pulse cyc=%0d got=%0b exp=%0b", i, mif.proto_err, (i == 2)); end
            @(negedge clk);
        end
        mif.md_op = 4'd5;
        #1;
        checks++;
        if (mif.md_out !== 32'd2) begin errors++; $display("FAIL proto_hi_kept got=%h exp=2", mif.md_out); end
        mif.md_op = 4'd6;
        #1;
        checks++;
        if (mif.md_out !== 32'd14) begin errors++; $display("FAIL proto_lo got=%h exp=e", mif.md_out); end
        drive(4'd8, 32'hA5A5_A5A5, 32'h0, 1'b1);
        @(negedge clk);
        model_apply(4'd8, 32'hA5A5_A5A5, 32'h0);
        drive(4'd6, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (mif.busy !== 1'b0 || mif.proto_err !== 1'b0) begin
            errors++; $display("FAIL mtlo_side busy=%0b proto_err=%0b exp=0,0", mif.busy, mif.proto_err);
        end
        checks++;
        if (mif.md_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mtlo_read got=%h exp=a5a5a5a5", mif.md_out); end
        mif.md_op = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive(4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
        @(negedge clk);
        drive(4'd8, 32'hCAFE_F00D, 32'h0, 1'b0);
        @(negedge clk);
        drive(4'd3, 32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        drive(4'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        #1;
        checks++;
        if (mif.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%0b exp=0", mif.busy); end
        for (int i = 0; i < int'(DIV_LAT) + 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (mif.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle cyc=%0d got=%0b exp=0", i, mif.busy); end
        end
        mif.md_op = 4'd5;
        #1;
        checks++;
        if (mif.md_out !== 32'h0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", mif.md_out); end
        mif.md_op = 4'd6;
        #1;
        checks++;
        if (mif.md_out !== 32'h0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", mif.md_out); end
        mif.md_op = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dmd;
        logic        ill;
        logic        prev_ill;
        int unsigned lat;
        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom_range(1, 8));
            a   = $urandom;
            b   = $urandom;
            dmd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) b = 32'h0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            lat = lat_of(op);
            drive(op, a, b, dmd);
            #1;
            checks++;
            if (mif.stall !== (dmd && lat != 0)) begin errors++; $display("FAIL rnd_stall_start n=%0d got=%0b exp=%0b", n, mif.stall, (dmd && lat != 0)); end
            @(negedge clk);
            model_apply(op, a, b);
            prev_ill = 1'b0;
            for (int i = 0; i < int'(lat); i++) begin
                ill = ($urandom_range(0, 3) == 0);
                dmd = 1'($urandom_range(0, 1));
                if (ill) drive(4'($urandom_range(1, 8)), $urandom, $urandom, dmd);
                else     drive(4'd0, $urandom, $urandom, dmd);
                #1;
                checks++;
                if (mif.busy !== 1'b1 || mif.stall !== dmd || mif.proto_err !== prev_ill) begin
                    errors++;
                    $display("FAIL rnd_busy n=%0d cyc=%0d busy=%0b stall=%0b perr=%0b exp=1,%0b,%0b", n, i, mif.busy, mif.stall, mif.proto_err, dmd, prev_ill);
                end
                prev_ill = ill;
                @(negedge clk);
            end
            drive(4'd5, 32'h0, 32'h0, 1'b0);
            #1;
            checks++;
            if (mif.busy !== 1'b0 || mif.proto_err !== prev_ill) begin
                errors++; $display("FAIL rnd_done n=%0d busy=%0b perr=%0b exp=0,%0b", n, mif.busy, mif.proto_err, prev_ill);
            end
            checks++;
            if (mif.md_out !== m_hi) begin errors++; $display("FAIL rnd_hi n=%0d op=%0d got=%h exp=%h", n, op, mif.md_out, m_hi); end
            mif.md_op = 4'd6;
            #1;
            checks++;
            if (mif.md_out !== m_lo) begin errors++; $display("FAIL rnd_lo n=%0d op=%0d got=%h exp=%h", n, op, mif.md_out, m_lo); end
            mif.md_op = 4'd0;
            @(negedge clk);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_hi   = 32'h0;
        m_lo   = 32'h0;
        reset  = 1'b1;
        drive(4'd0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        test_mult_div();
        test_stall();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_LAT, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 md_op  input  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
REQ-006 src_a  input  32  rs operand (forwarded).
REQ-007 src_b  input  32  rt operand (forwarded).
REQ-008 d_is_md  input  1  D-stage instruction is any op 1-8.
REQ-009 busy  output  1  unit computing.
REQ-010 stall  output  1  freeze D stage, bubble into E.
REQ-011 md_out  output  32  MFHI/MFLO read data.
REQ-012 proto_err  output  1  one-cycle pulse on illegal issue.

Function
REQ-013 Start cycle = cycle where md_op is 1-4 and busy=0; operands sampled at its closing edge.
REQ-014 busy SHALL be high for exactly MUL_LAT (mult) or DIV_LAT (div) cycles immediately following the start cycle, via down-counter loaded at start, busy = (count != 0).
REQ-015 HI/LO SHALL update at the edge ending the last busy cycle; new values visible the first cycle busy=0.
REQ-016 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned product.
REQ-017 DIV: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; DIVU unsigned.
REQ-018 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0.
REQ-019 Divisor zero: HI/LO unchanged; busy still runs full DIV_LAT.
REQ-020 MTHI/MTLO with busy=0: HI/LO = src_a at closing edge; no busy.
REQ-021 md_out combinational: HI when md_op=5, LO when md_op=6, else 0.
REQ-022 stall = d_is_md & (busy | E-stage start cycle).
REQ-023 Any md_op 1-8 while busy=1 SHALL be ignored (no state change) and pulse proto_err next cycle.
REQ-024 Last busy cycle coinciding with a new start: impossible by REQ-013; op in that cycle SHALL take REQ-023 path.
REQ-025 Counter SHALL not wrap; holds 0 when idle.

Reset
REQ-026 Reset SHALL clear HI, LO, counter, busy, proto_err to 0; stall and md_out follow combinationally (0 with md_op=0, d_is_md=0).
REQ-027 Reset mid-operation SHALL abort; pending result discarded, HI/LO = 0 next cycle.
REQ-028 Reset SHALL dominate any simultaneous start or MTHI/MTLO.

Structure
REQ-029 Op encodings 0-8 and default latencies SHALL live in the shared macros include alongside instruction field macros.
REQ-030 Result computed at start, held in a pending {HI,LO} register; no sub-module required; an optional sub-module mdu_count may hold the latency counter.

Verification
REQ-031 MULT src_a=0xFFFFFFFE, src_b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-032 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged after 10 busy cycles.
REQ-033 MULT started, d_is_md=1 in each following cycle -> stall high in start cycle and all 5 busy cycles, low once busy=0.
REQ-034 MTHI 0x12345678 while busy -> proto_err pulse, HI unchanged; MTLO 0xA5A5A5A5 when idle -> md_op=6 gives md_out=0xA5A5A5A5.
REQ-035 Reset asserted on busy cycle 3 of DIV -> next cycle busy=0, HI=LO=0, no later update.
